lsu_riscv: RTL and testbench
============================

# lsu_riscv

Load-store unit between the main decoder/datapath and the data memory. Takes the decoder's memory request (enable, write flag, 3-bit access size), the ALU-computed address and the rs2 store data. Drives a word-organised data memory with byte enables and a ready handshake, and returns sign/zero-extended load data to the register-file write-back mux. Stalls the core until the memory access completes and flags misaligned accesses.

## Interface
Parameters: none. Size encodings are fixed: LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  1  memory access requested this instruction (decoder mem_req)
- core_we_i  in  1  1 = store, 0 = load (decoder mem_we)
- core_size_i  in  3  access size/extension (decoder mem_size)
- core_addr_i  in  32  byte address from ALU
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  extended load data for write-back
- core_stall_o  out  1  hold PC and pipeline this cycle
- misaligned_o  out  1  access misaligned; no memory access issued
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  memory address
- mem_wd_o  out  32  memory write data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory completed request this cycle

## Operation
- Misalignment is combinational. H/HU with addr[0]=1 is misaligned. W with addr[1:0]≠0 is misaligned. Sizes 3, 6 and 7 are treated as W.
- misaligned_o = core_req_i & misaligned. When misaligned is set: mem_req_o=0 and core_stall_o=0 (trap handled upstream).
- Valid request: go = core_req_i & ~misaligned.
- mem_req_o = go; mem_we_o = go & core_we_i; mem_addr_o = core_addr_i.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0]
  - H/HU: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
  - All zero when go=0.
- Write data:
  - B: store byte replicated ×4
  - H: store halfword replicated ×2
  - W: unchanged
- Load data, selected from mem_rd_i by addr:
  - B: byte at addr[1:0], sign-extended
  - BU: byte at addr[1:0], zero-extended
  - H: halfword at addr[1], sign-extended
  - HU: halfword at addr[1], zero-extended
  - W: whole word
  - core_rd_o is valid only in the completion cycle.
- FSM, one register busy_q: IDLE (0) / WAIT (1).
  - IDLE: if go, core_stall_o=1 and next state is WAIT.
  - WAIT: core_stall_o = ~mem_ready_i.
    - mem_ready_i=1: access completes and next state is IDLE.
    - Otherwise stay in WAIT.
  - busy_q <= core_stall_o.
- mem_ready_i is ignored in IDLE.

## Timing
- Reset: busy_q=0. All registered state is cleared immediately on rst_ni low. Outputs during reset are combinational functions of inputs with busy_q=0; with core_req_i=0, every output is 0.
- Minimum access is 2 cycles: C0 (IDLE, stall=1), C1 (WAIT, ready=1, stall=0, rd valid). The instruction retires at the end of C1.
- Each extra cycle of mem_ready_i=0 adds one stall cycle. There is no timeout.
- Core inputs hold stable while stalled. mem_* outputs are therefore stable from C0 to completion.
- Back-to-back accesses: after completion busy_q=0. The next request starts a fresh C0, so there are no zero-gap accesses.
- Reset asserted in WAIT: returns to IDLE. The pending access is abandoned; memory must tolerate this.
- core_req_i dropping in WAIT is illegal. If it happens: stall=0 and busy_q clears next cycle.

## Test plan
- LW at 0x100, mem_rd_i=0xDEADBEEF, ready in C1:
  - C0: mem_req_o=1, be=4'b1111, stall=1.
  - C1: stall=0, core_rd_o=0xDEADBEEF.
- LB/LBU at 0x103, mem_rd_i=0x80FF_1234:
  - LB: core_rd_o=0xFFFFFF80.
  - LBU: core_rd_o=0x00000080.
  - LH at 0x102: 0xFFFF80FF. LHU at 0x102: 0x000080FF.
- SB at 0x101, core_wd_i=0x000000AB: mem_we_o=1, be=4'b0010, mem_wd_o=0xABABABAB.
- SH at 0x102, core_wd_i=0x00001234: be=4'b1100, mem_wd_o=0x12341234.
- LW with mem_ready_i low for 3 cycles after C0: stall=1 for 4 cycles; released in the cycle ready=1; rd valid in that cycle.
- Misalignment: LH at 0x101 or SW at 0x102 gives misaligned_o=1, mem_req_o=0, be=0, stall=0.
- Reset: rst_ni pulsed low in WAIT drops busy_q to 0 asynchronously. After release with core_req_i=1 held, a fresh C0 occurs (stall=1, ready ignored).

Source files
------------

// File: rtl/lsu_riscv.sv
// lsu_riscv: load-store unit between the decoder/datapath and a word-organised
// data memory.
//
// Core side:
//   core_req_i/core_we_i/core_size_i  memory request, store flag, access size
//   core_addr_i/core_wd_i             byte address, store data (rs2)
//   core_rd_o                         extended load data (completion cycle only)
//   core_stall_o                      hold PC/pipeline this cycle
//   misaligned_o                      misaligned request, nothing issued
// Memory side:
//   mem_req_o/mem_we_o/mem_be_o       request, write, byte enables
//   mem_addr_o/mem_wd_o               address, replicated write data
//   mem_rd_i/mem_ready_i              read word, access completed this cycle
module lsu_riscv (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t busy_q, busy_d;

    logic        is_b, is_h, is_w, is_u;
    logic        misaligned, go, done;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Unused encodings 3/6/7 fall through to word accesses.
    assign is_b = (core_size_i == LDST_B) || (core_size_i == LDST_BU);
    assign is_h = (core_size_i == LDST_H) || (core_size_i == LDST_HU);
    assign is_w = ~is_b & ~is_h;
    assign is_u = core_size_i[2];

    assign misaligned = (is_h & core_addr_i[0])
                      | (is_w & (core_addr_i[1:0] != 2'b00));
    assign go         = core_req_i & ~misaligned;

    assign misaligned_o = core_req_i & misaligned;
    assign mem_req_o    = go;
    assign mem_we_o     = go & core_we_i;
    assign mem_addr_o   = core_addr_i;

    always_comb begin
        mem_be_o = 4'b0000;
        mem_wd_o = 32'h0;
        if (go) begin
            if (is_b) begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end else if (is_h) begin
                mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                mem_wd_o = {2{core_wd_i[15:0]}};
            end else begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
            end
        end
    end

    assign ld_byte = mem_rd_i[{core_addr_i[1:0], 3'b000} +: 8];
    assign ld_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        ld_ext = mem_rd_i;
        if (is_b)
            ld_ext = {{24{~is_u & ld_byte[7]}}, ld_byte};
        else if (is_h)
            ld_ext = {{16{~is_u & ld_half[15]}}, ld_half};
    end

    // Load data is only driven in the completion cycle of a load.
    assign done      = (busy_q == WAIT) & mem_ready_i & go;
    assign core_rd_o = (done & ~core_we_i) ? ld_ext : 32'h0;

    // mem_ready_i is ignored in IDLE, so every access takes at least 2 cycles.
    always_comb begin
        core_stall_o = 1'b0;
        case (busy_q)
            IDLE: core_stall_o = go;
            WAIT: core_stall_o = go & ~mem_ready_i;
            default: core_stall_o = 1'b0;
        endcase
        busy_d = core_stall_o ? WAIT : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            busy_q <= IDLE;
        else
            busy_q <= busy_d;
    end

endmodule

// File: tb/tb_lsu_riscv.sv
// tb_lsu_riscv: directed scoreboard bench for lsu_riscv.
// Stimulus queues expected retire records; a monitor checks them on retire.
module tb_lsu_riscv;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wd_i = 32'h0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misaligned_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = 32'h0;
    logic        mem_ready_i = 1'b0;

    lsu_riscv dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misaligned_o (misaligned_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_wd;
        logic        we;
        logic        mis;
        logic        req;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Retire point: request present and not stalled (completion or trap).
    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt = 0;
        end else if (core_stall_o) begin
            stall_cnt++;
        end else if (core_req_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("misaligned", {31'h0, misaligned_o}, {31'h0, e.mis});
                chk("mem_req", {31'h0, mem_req_o}, {31'h0, e.req});
                chk("mem_we", {31'h0, mem_we_o}, {31'h0, e.we});
                chk("mem_be", {28'h0, mem_be_o}, {28'h0, e.be});
                chk("core_rd", core_rd_o, e.rd);
                if (e.chk_wd)
                    chk("mem_wd", mem_wd_o, e.wd);
                chk("stall_cycles", stall_cnt, e.stalls);
            end
            stall_cnt = 0;
        end
    end

    task automatic access(input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int waits,
                          input logic c0_ready, input logic [31:0] exp_rd,
                          input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic mis);
        exp_t e;
        e.rd = exp_rd;
        e.be = exp_be;
        e.wd = exp_wd;
        e.chk_wd = ~mis;
        e.we = we & ~mis;
        e.mis = mis;
        e.req = ~mis;
        e.stalls = mis ? 0 : 1 + waits;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        core_req_i = 1'b1;
        core_we_i = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i = wd;
        mem_rd_i = rdata;
        mem_ready_i = c0_ready;
        if (!mis) begin
            @(posedge clk_i);
            #1;
            repeat (waits) begin
                mem_ready_i = 1'b0;
                @(posedge clk_i);
                #1;
            end
            mem_ready_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        core_req_i = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_stall", {31'h0, core_stall_o}, 32'h0);
        chk("rst_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_be", {28'h0, mem_be_o}, 32'h0);
        chk("rst_rd", core_rd_o, 32'h0);
        chk("rst_wd", mem_wd_o, 32'h0);
        chk("rst_mis", {31'h0, misaligned_o}, 32'h0);
        #10;
        rst_ni = 1'b1;

        access(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0,
               32'hDEADBEEF, 4'b1111, 0, 0);
        access(0, 3'd0, 32'h103, 0, 32'h80FF1234, 0, 0,
               32'hFFFFFF80, 4'b1000, 0, 0);
        access(0, 3'd4, 32'h103, 0, 32'h80FF1234, 0, 0,
               32'h00000080, 4'b1000, 0, 0);
        access(0, 3'd1, 32'h102, 0, 32'h80FF1234, 0, 0,
               32'hFFFF80FF, 4'b1100, 0, 0);
        access(0, 3'd5, 32'h102, 0, 32'h80FF1234, 0, 0,
               32'h000080FF, 4'b1100, 0, 0);
        access(1, 3'd0, 32'h101, 32'h000000AB, 0, 0, 0,
               0, 4'b0010, 32'hABABABAB, 0);
        access(1, 3'd1, 32'h102, 32'h00001234, 0, 0, 0,
               0, 4'b1100, 32'h12341234, 0);
        access(1, 3'd2, 32'h104, 32'hCAFEF00D, 0, 1, 0,
               0, 4'b1111, 32'hCAFEF00D, 0);
        access(0, 3'd2, 32'h200, 0, 32'h12345678, 3, 0,
               32'h12345678, 4'b1111, 0, 0);
        access(0, 3'd1, 32'h101, 0, 32'h55555555, 0, 0,
               0, 4'b0000, 0, 1);
        access(1, 3'd2, 32'h102, 32'h11223344, 0, 0, 0,
               0, 4'b0000, 0, 1);
        access(0, 3'd0, 32'h100, 0, 32'h0000007F, 0, 1,
               32'h0000007F, 4'b0001, 0, 0);
        access(0, 3'd1, 32'h100, 0, 32'h12348001, 0, 0,
               32'hFFFF8001, 4'b0011, 0, 0);
        access(0, 3'd3, 32'h101, 0, 0, 0, 0,
               0, 4'b0000, 0, 1);
        access(0, 3'd7, 32'h108, 0, 32'hA5A5_0F0F, 0, 0,
               32'hA5A50F0F, 4'b1111, 0, 0);

        // Reset pulsed while waiting; access restarts with a fresh C0.
        @(posedge clk_i);
        #1;
        core_req_i = 1'b1;
        core_we_i = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h300;
        mem_rd_i = 32'h0BADF00D;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b1;
        #1;
        chk("wait_release", {31'h0, core_stall_o}, 32'h0);
        rst_ni = 1'b0;
        #1;
        chk("rst_in_wait_stall", {31'h0, core_stall_o}, 32'h1);
        begin
            exp_t e;
            e.rd = 32'h0BADF00D;
            e.be = 4'b1111;
            e.wd = 0;
            e.chk_wd = 1;
            e.we = 0;
            e.mis = 0;
            e.req = 1;
            e.stalls = 1;
            exp_q.push_back(e);
        end
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        core_req_i = 1'b0;
        mem_ready_i = 1'b0;

        repeat (3) @(posedge clk_i);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
